multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
Main sequencing state machine for the multicycle ARM core. It decodes Op/Funct and steps the shared datapath through fetch, decode, execute, memory and writeback. Each step drives the mux selects, write enables and ALUOp. The conditional-logic block gates its RegW/MemW/NextPC/Branch outputs with CondEx. A memory-ready handshake stalls fetch and data-memory steps, and a retired-instruction counter feeds performance monitoring.

Parameters:
RETIRE_W, 32, width of retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
Op  input  2  instruction[27:26]
Funct  input  6  instruction[25:20]
mem_ready  input  1  memory completes current access this cycle
IRWrite  output  1  load instruction register
NextPC  output  1  PC update request (pre-CondEx)
AdrSrc  output  1  0=PC, 1=ALUResult as memory address
ALUSrcA  output  1  0=register A, 1=PC
ALUSrcB  output  2  00=reg B, 01=ExtImm, 10=constant 4
ALUOp  output  1  1=decode ALU op from Funct, 0=add
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
RegW  output  1  register write request (pre-CondEx)
MemW  output  1  memory write request (pre-CondEx)
Branch  output  1  branch request (pre-CondEx)
instret  output  1  one-cycle pulse when an instruction completes
retired  output  RETIRE_W  count of completed instructions
illegal  output  1  sticky flag for an undefined Op

Behaviour:
- Reset (async, any cycle, including mid-instruction): state=FETCH, retired=0, illegal=0, instret=0. All outputs take their FETCH values combinationally. IRWrite and NextPC are 0 while mem_ready=0.
- Default for every output not listed for a state: 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - IRWrite=NextPC=mem_ready (Mealy).
  - Stay while !mem_ready; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state:
  - Op=00, Funct[5]=0 -> EXECUTER
  - Op=00, Funct[5]=1 -> EXECUTEI
  - Op=01 -> MEMADR
  - Op=10 -> BRANCH
  - Op=11 -> ILLEGAL
- MEMADR: ALUSrcA=0, ALUSrcB=01. Funct[0]=1 (LDR) -> MEMREAD; Funct[0]=0 (STR) -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold while !mem_ready; go to MEMWB when mem_ready=1.
- MEMWB: ResultSrc=01, RegW=1. Go to FETCH; instret=1.
- MEMWRITE: AdrSrc=1, MemW=1 for every cycle in the state. Hold while !mem_ready; when mem_ready=1 go to FETCH with instret=1.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Go to ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Go to ALUWB.
- ALUWB: ResultSrc=00, RegW=1. Go to FETCH; instret=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1. Go to FETCH; instret=1.
- ILLEGAL:
  - All control outputs are 0 and illegal=1.
  - The FSM stays in ILLEGAL until reset; no instret.
- Retire counting:
  - instret is combinational from state plus mem_ready.
  - retired increments on the clock edge where instret=1 and wraps from all-ones to 0.
  - An instruction retires even if its CondEx is false (it still completed).
- Minimum latency: branch 3 cycles, data-processing 4, STR 4, LDR 5. Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- An unencoded state value decodes to FETCH on the next edge, never x.

Decomposition:
- Package multicycle_pkg:
  - state_t enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, ILLEGAL.
  - Localparams for ALUSrcB and ResultSrc encodings.
  - Op constants OP_DP=00, OP_MEM=01, OP_BR=10.
- Sub-module main_fsm_outdec: a purely combinational state -> control-word lookup. It keeps the top level to the state register, next-state logic and retire counter.

Test Plan:
- ADD reg, mem_ready=1: Op=00, Funct=000100 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH; RegW=1 only in ALUWB; ALUOp=1 only in EXECUTER; retired 0->1.
- LDR with 2 stall cycles: Op=01, Funct=011001, mem_ready low 2 cycles in MEMREAD -> 7 cycles total; AdrSrc=1 throughout MEMREAD; RegW with ResultSrc=01 in MEMWB; instret once.
- STR with fetch stall: mem_ready=0 for 3 cycles in FETCH -> IRWrite=NextPC=0 for those cycles, then 1 for one cycle; MemW=1 in MEMWRITE; return to FETCH.
- Branch: Op=10 -> BRANCH asserts Branch=1, ALUSrcB=01, ResultSrc=10; back to FETCH after 3 cycles.
- Illegal Op=11: illegal rises after DECODE and stays high 20 cycles with RegW=MemW=NextPC=0; reset clears illegal and returns to FETCH.
- Async reset asserted mid-MEMWRITE between clock edges -> state=FETCH and MemW=0 immediately; retired=0; after counter preload to all-ones, one retire wraps it to 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: state, encoding and control-word types shared by the main FSM
package multicycle_pkg;
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BRANCH, ILLEGAL
   } state_t;
   localparam logic [1:0] SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10;
   localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10;
   typedef struct packed {
      logic       irwrite;
      logic       nextpc;
      logic       adrsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       aluop;
      logic [1:0] resultsrc;
      logic       regw;
      logic       memw;
      logic       branch;
      logic       instret;
      logic       illegal;
   } ctrl_t;
endpackage

// File: rtl/main_fsm_outdec.sv
// main_fsm_outdec: combinational state to control-word lookup
module main_fsm_outdec
   import multicycle_pkg::*;
(
   input  state_t state_i,
   input  logic   mem_ready_i,
   output ctrl_t  ctrl_o
);
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         FETCH: begin
            ctrl_o.irwrite   = mem_ready_i;
            ctrl_o.nextpc    = mem_ready_i;
            ctrl_o.alusrca   = 1'b1;
            ctrl_o.alusrcb   = SRCB_FOUR;
            ctrl_o.resultsrc = RES_ALU;
         end
         DECODE: begin
            ctrl_o.alusrca   = 1'b1;
            ctrl_o.alusrcb   = SRCB_FOUR;
            ctrl_o.resultsrc = RES_ALU;
         end
         MEMADR: ctrl_o.alusrcb = SRCB_IMM;
         MEMREAD: begin
            ctrl_o.adrsrc    = 1'b1;
            ctrl_o.resultsrc = RES_ALUOUT;
         end
         MEMWB: begin
            ctrl_o.resultsrc = RES_DATA;
            ctrl_o.regw      = 1'b1;
            ctrl_o.instret   = 1'b1;
         end
         MEMWRITE: begin
            ctrl_o.adrsrc  = 1'b1;
            ctrl_o.memw    = 1'b1;
            ctrl_o.instret = mem_ready_i;
         end
         EXECUTER: begin
            ctrl_o.alusrcb = SRCB_REG;
            ctrl_o.aluop   = 1'b1;
         end
         EXECUTEI: begin
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = 1'b1;
         end
         ALUWB: begin
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.regw      = 1'b1;
            ctrl_o.instret   = 1'b1;
         end
         BRANCH: begin
            ctrl_o.alusrcb   = SRCB_IMM;
            ctrl_o.resultsrc = RES_ALU;
            ctrl_o.branch    = 1'b1;
            ctrl_o.instret   = 1'b1;
         end
         ILLEGAL: ctrl_o.illegal = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: sequencing FSM and retired-instruction counter of the multicycle ARM core
module multicycle_main_fsm
   import multicycle_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          Op,
   input  logic [5:0]          Funct,
   input  logic                mem_ready,
   output logic                IRWrite,
   output logic                NextPC,
   output logic                AdrSrc,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic                ALUOp,
   output logic [1:0]          ResultSrc,
   output logic                RegW,
   output logic                MemW,
   output logic                Branch,
   output logic                instret,
   output logic [RETIRE_W-1:0] retired,
   output logic                illegal
);
   state_t state_q, state_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;
   ctrl_t ctrl;
   logic unused_funct;
   assign unused_funct = ^Funct[4:1];
   main_fsm_outdec u_outdec (.state_i(state_q), .mem_ready_i(mem_ready), .ctrl_o(ctrl));
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:              state_d = mem_ready ? DECODE : FETCH;
         DECODE:             state_d = Op == OP_DP  ? (Funct[5] ? EXECUTEI : EXECUTER) :
                                       Op == OP_MEM ? MEMADR :
                                       Op == OP_BR  ? BRANCH : ILLEGAL;
         MEMADR:             state_d = Funct[0] ? MEMREAD : MEMWRITE;
         MEMREAD:            state_d = mem_ready ? MEMWB : MEMREAD;
         MEMWRITE:           state_d = mem_ready ? FETCH : MEMWRITE;
         EXECUTER, EXECUTEI: state_d = ALUWB;
         ILLEGAL:            state_d = ILLEGAL;
         default:            state_d = FETCH;
      endcase
   end
   assign retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, ctrl.instret};
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end
   assign IRWrite   = ctrl.irwrite;
   assign NextPC    = ctrl.nextpc;
   assign AdrSrc    = ctrl.adrsrc;
   assign ALUSrcA   = ctrl.alusrca;
   assign ALUSrcB   = ctrl.alusrcb;
   assign ALUOp     = ctrl.aluop;
   assign ResultSrc = ctrl.resultsrc;
   assign RegW      = ctrl.regw;
   assign MemW      = ctrl.memw;
   assign Branch    = ctrl.branch;
   assign instret   = ctrl.instret;
   assign illegal   = ctrl.illegal;
   assign retired   = retired_q;
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: random instruction streams checked cycle by cycle against an expected control trace
module tb_multicycle_main_fsm;
   logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
   logic [1:0] Op = '0;
   logic [5:0] Funct = '0;
   logic IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, instret, illegal;
   logic [1:0] ALUSrcB, ResultSrc;
   logic [3:0] retired;
   logic [13:0] obs;
   int total = 0, bad = 0, exp_ret = 0;
   always #5 clk = ~clk;
   multicycle_main_fsm #(.RETIRE_W(4)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
      .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .RegW(RegW),
      .MemW(MemW), .Branch(Branch), .instret(instret), .retired(retired), .illegal(illegal)
   );
   assign obs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, RegW, MemW, Branch, instret, illegal};
   function automatic logic [13:0] w(input logic irw, npc, adr, sa, input logic [1:0] sb,
                                     input logic ao, input logic [1:0] rs, input logic rw, mw, br, ir, il);
      return {irw, npc, adr, sa, sb, ao, rs, rw, mw, br, ir, il};
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic step(input string tag, input logic mr, input logic [13:0] e);
      @(negedge clk);
      mem_ready = mr;
      #1;
      chk({tag, ".ctl"}, 32'(obs), 32'(e));
      chk({tag, ".ret"}, 32'(retired), exp_ret);
      if (e[1]) exp_ret = (exp_ret + 1) % 16;
   endtask
   task automatic do_reset();
      mem_ready = 1'b0;
      #1 reset = 1'b1;
      #1;
      exp_ret = 0;
      chk("rst.ctl", 32'(obs), 32'(w(0,0,0,1,2'b10,0,2'b10,0,0,0,0,0)));
      chk("rst.ret", 32'(retired), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic do_instr(input logic [1:0] op, input logic [5:0] fn, input int fs, input int ms, input int cut);
      Op = op;
      Funct = fn;
      repeat (fs) step("fetch", 1'b0, w(0,0,0,1,2'b10,0,2'b10,0,0,0,0,0));
      step("fetch", 1'b1, w(1,1,0,1,2'b10,0,2'b10,0,0,0,0,0));
      step("decode", 1'($urandom), w(0,0,0,1,2'b10,0,2'b10,0,0,0,0,0));
      if (op == 2'b00) begin
         step("exec", 1'($urandom), fn[5] ? w(0,0,0,0,2'b01,1,2'b00,0,0,0,0,0) : w(0,0,0,0,2'b00,1,2'b00,0,0,0,0,0));
         step("aluwb", 1'($urandom), w(0,0,0,0,2'b00,0,2'b00,1,0,0,1,0));
      end else if (op == 2'b01) begin
         step("memadr", 1'($urandom), w(0,0,0,0,2'b01,0,2'b00,0,0,0,0,0));
         if (fn[0]) begin
            repeat (ms) step("memrd", 1'b0, w(0,0,1,0,2'b00,0,2'b00,0,0,0,0,0));
            step("memrd", 1'b1, w(0,0,1,0,2'b00,0,2'b00,0,0,0,0,0));
            step("memwb", 1'($urandom), w(0,0,0,0,2'b00,0,2'b01,1,0,0,1,0));
         end else if (cut > 0) begin
            repeat (cut) step("memwr", 1'b0, w(0,0,1,0,2'b00,0,2'b00,0,1,0,0,0));
            do_reset();
         end else begin
            repeat (ms) step("memwr", 1'b0, w(0,0,1,0,2'b00,0,2'b00,0,1,0,0,0));
            step("memwr", 1'b1, w(0,0,1,0,2'b00,0,2'b00,0,1,0,1,0));
         end
      end else if (op == 2'b10) begin
         step("branch", 1'($urandom), w(0,0,0,0,2'b01,0,2'b10,0,0,1,1,0));
      end else begin
         repeat (20) step("illegal", 1'($urandom), w(0,0,0,0,2'b00,0,2'b00,0,0,0,0,1));
         do_reset();
      end
   endtask
   initial begin
      do_reset();
      do_instr(2'b00, 6'b000100, 0, 0, 0);
      do_instr(2'b01, 6'b011001, 0, 2, 0);
      do_instr(2'b01, 6'b011000, 3, 0, 0);
      do_instr(2'b10, 6'b000000, 0, 0, 0);
      do_instr(2'b11, 6'b000000, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         int r;
         r = $urandom_range(0, 9);
         do_instr(r == 9 ? 2'b11 : 2'(r % 3), 6'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 0);
      end
      repeat (5) do_instr(2'b00, 6'b100000, 0, 0, 0);
      do_instr(2'b01, 6'b011000, 1, 5, 2);
      for (int i = 0; i < 20; i++)
         do_instr(2'($urandom_range(0, 2)), 6'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
